// File: rtl/fb_loader_pkg.sv
// Shared frame-buffer definitions for the byte-stream loader and the VGA read side.
// Pixel geometry, address width, loader state encoding and RGB565 field layout.
package fb_pkg;

  localparam int FB_W    = 400;
  localparam int FB_H    = 300;
  localparam int FB_NPIX = FB_W * FB_H;
  localparam int FB_AW   = 18;

  localparam int FB_R_W   = 5;
  localparam int FB_G_W   = 6;
  localparam int FB_B_W   = 5;
  localparam int FB_PIX_W = FB_R_W + FB_G_W + FB_B_W;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_SYNC = 3'd1,
    ST_HI   = 3'd2,
    ST_LO   = 3'd3,
    ST_FIN  = 3'd4
  } fb_state_e;

  // The VGA side scans 800x600 and doubles each stored pixel in both directions.
  function automatic logic [FB_AW-1:0] fb_vga_addr(input logic [9:0] x, input logic [9:0] y);
    logic [FB_AW-1:0] row;
    logic [FB_AW-1:0] col;
    row = FB_AW'(y >> 1);
    col = FB_AW'(x >> 1);
    return FB_AW'(row * FB_AW'(FB_W)) + col;
  endfunction

endpackage

// File: rtl/fb_loader_if.sv
// Byte-stream input and frame-buffer write-side signals of the loader.
interface fb_loader_if;
  import fb_pkg::*;

  logic [7:0]          rx_data;
  logic                rx_valid;
  logic                rx_ready;
  logic                abort;
  logic                we;
  logic [FB_AW-1:0]    waddr;
  logic [FB_PIX_W-1:0] wdata;
  logic                busy;
  logic                done;
  logic                err;

  modport master (
    output rx_data, rx_valid, abort,
    input  rx_ready, we, waddr, wdata, busy, done, err
  );

  modport slave (
    input  rx_data, rx_valid, abort,
    output rx_ready, we, waddr, wdata, busy, done, err
  );

endinterface

// File: rtl/fb_loader_timeout.sv
// Inter-byte watchdog: reloads on clear, counts down while enabled, flags expiry at zero.
module fb_timeout #(
  parameter int               CNT_W    = 24,
  parameter logic [CNT_W-1:0] LOAD_VAL = '1
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_clr,
  input  logic i_en,
  output logic o_expire
);

  logic [CNT_W-1:0] r_cnt;
  logic             w_zero;

  assign w_zero   = (r_cnt == '0);
  assign o_expire = i_en && w_zero;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt <= LOAD_VAL;
    end else if (i_clr) begin
      r_cnt <= LOAD_VAL;
    end else if (i_en && !w_zero) begin
      r_cnt <= r_cnt - 1'b1;
    end
  end

endmodule

// File: rtl/fb_loader.sv
// Frame loader: hunts for the two-byte sync header, then packs byte pairs into
// RGB565 pixel writes for the frame-buffer RAM, with abort and inter-byte timeout.
//
//   state | meaning
//   IDLE  | hunting for SYNC0
//   SYNC  | SYNC0 seen, expecting SYNC1
//   HI    | waiting for a pixel's high byte
//   LO    | waiting for a pixel's low byte, write on arrival
//   FIN   | one-cycle frame end, input stalled, done issued on exit
module fb_loader
  import fb_pkg::*;
#(
  parameter int          PIX_W   = FB_W,
  parameter int          PIX_H   = FB_H,
  parameter logic [7:0]  SYNC0   = 8'hA5,
  parameter logic [7:0]  SYNC1   = 8'h5A,
  parameter logic [23:0] TIMEOUT = 24'd5_000_000
) (
  input  logic       CLK,
  input  logic       RST,
  fb_loader_if.slave bus
);

  localparam logic [FB_AW-1:0] LAST_PIX = FB_AW'(PIX_W * PIX_H - 1);

  fb_state_e           r_state;
  logic [FB_AW-1:0]    r_pix;
  logic [7:0]          r_hi;
  logic                r_we;
  logic [FB_AW-1:0]    r_waddr;
  logic [FB_PIX_W-1:0] r_wdata;
  logic                r_busy;
  logic                r_done;
  logic                r_err;
  logic                r_rx_ready;

  logic w_accept;
  logic w_in_pixel;
  logic w_expire;

  assign w_accept   = bus.rx_valid && r_rx_ready;
  assign w_in_pixel = (r_state == ST_HI) || (r_state == ST_LO);

  fb_timeout #(
    .CNT_W    (24),
    .LOAD_VAL (TIMEOUT - 24'd1)
  ) u_timeout (
    .i_clk    (CLK),
    .i_rst_n  (RST),
    .i_clr    (w_accept || !w_in_pixel),
    .i_en     (w_in_pixel),
    .o_expire (w_expire)
  );

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_state    <= ST_IDLE;
      r_pix      <= '0;
      r_hi       <= '0;
      r_we       <= 1'b0;
      r_waddr    <= '0;
      r_wdata    <= '0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_err      <= 1'b0;
      r_rx_ready <= 1'b0;
    end else begin
      r_we       <= 1'b0;
      r_done     <= 1'b0;
      r_err      <= 1'b0;
      r_rx_ready <= 1'b1;
      case (r_state)
        ST_IDLE: begin
          if (!bus.abort && w_accept && bus.rx_data == SYNC0) begin
            r_state <= ST_SYNC;
          end
        end
        ST_SYNC: begin
          if (bus.abort) begin
            r_state <= ST_IDLE;
          end else if (w_accept) begin
            if (bus.rx_data == SYNC1) begin
              r_state <= ST_HI;
              r_busy  <= 1'b1;
            end else if (bus.rx_data != SYNC0) begin
              r_state <= ST_IDLE;
            end
          end
        end
        ST_HI: begin
          // Abort/timeout win over a byte arriving in the same cycle.
          if (bus.abort || w_expire) begin
            r_err   <= 1'b1;
            r_busy  <= 1'b0;
            r_pix   <= '0;
            r_state <= ST_IDLE;
          end else if (w_accept) begin
            r_hi    <= bus.rx_data;
            r_state <= ST_LO;
          end
        end
        ST_LO: begin
          if (bus.abort || w_expire) begin
            r_err   <= 1'b1;
            r_busy  <= 1'b0;
            r_pix   <= '0;
            r_state <= ST_IDLE;
          end else if (w_accept) begin
            r_we    <= 1'b1;
            r_waddr <= r_pix;
            r_wdata <= {r_hi, bus.rx_data};
            if (r_pix == LAST_PIX) begin
              r_busy     <= 1'b0;
              r_rx_ready <= 1'b0;
              r_state    <= ST_FIN;
            end else begin
              r_pix   <= r_pix + 1'b1;
              r_state <= ST_HI;
            end
          end
        end
        ST_FIN: begin
          r_done  <= 1'b1;
          r_pix   <= '0;
          r_state <= ST_IDLE;
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.rx_ready = r_rx_ready;
  assign bus.we       = r_we;
  assign bus.waddr    = r_waddr;
  assign bus.wdata    = r_wdata;
  assign bus.busy     = r_busy;
  assign bus.done     = r_done;
  assign bus.err      = r_err;

endmodule

// File: tb/tb_fb_loader.sv
// Bench for fb_loader on a 4x2 frame with a 16-cycle byte timeout.
module tb_fb_loader;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  fb_loader_if bus ();

  fb_loader #(
    .PIX_W   (4),
    .PIX_H   (2),
    .SYNC0   (8'hA5),
    .SYNC1   (8'h5A),
    .TIMEOUT (24'd16)
  ) dut (
    .CLK (clk),
    .RST (rst_n),
    .bus (bus)
  );

  int checks = 0;
  int errors = 0;

  // Observed writes and pulse counts, sampled just after each rising edge.
  logic [33:0] act_q[$];
  logic [33:0] exp_q[$];
  int n_done = 0;
  int n_err  = 0;
  int n_nrdy = 0;

  always @(posedge clk) begin
    #1;
    if (rst_n) begin
      if (bus.we) act_q.push_back({bus.waddr, bus.wdata});
      if (bus.done) n_done++;
      if (bus.err) n_err++;
      if (!bus.rx_ready) n_nrdy++;
    end
  end

  task automatic chk(input string tag, input logic [33:0] obs, input logic [33:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Called at a falling edge; returns at the falling edge after the transfer.
  task automatic send(input logic [7:0] b, input int gap);
    int n;
    bus.rx_valid = 1'b0;
    repeat (gap) @(negedge clk);
    bus.rx_data  = b;
    bus.rx_valid = 1'b1;
    n = 0;
    while (!bus.rx_ready && n < 8) begin
      @(negedge clk);
      n++;
    end
    chk("ready_wait", 34'(n < 8), 34'd1);
    @(negedge clk);
    bus.rx_valid = 1'b0;
  endtask

  task automatic close_abort(input string tag);
    bus.abort = 1'b1;
    @(negedge clk);
    bus.abort = 1'b0;
    chk({tag, "_err"}, 34'(bus.err), 34'd1);
    chk({tag, "_busy"}, 34'(bus.busy), 34'd0);
    @(negedge clk);
    chk({tag, "_err_pulse"}, 34'(bus.err), 34'd0);
  endtask

  task automatic drain(input string tag);
    int n;
    chk({tag, "_nwr"}, 34'(act_q.size()), 34'(exp_q.size()));
    n = (act_q.size() < exp_q.size()) ? act_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) chk({tag, "_wr"}, act_q[i], exp_q[i]);
    act_q.delete();
    exp_q.delete();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
    $fatal(1);
  end

  initial begin
    int nd0, ne0, nr0;
    logic [7:0] b, hi, lo;

    rst_n        = 1'b0;
    bus.rx_data  = 8'h00;
    bus.rx_valid = 1'b0;
    bus.abort    = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_rdy", 34'(bus.rx_ready), 34'd0);
    chk("rst_we", 34'(bus.we), 34'd0);
    chk("rst_waddr", 34'(bus.waddr), 34'd0);
    chk("rst_wdata", 34'(bus.wdata), 34'd0);
    chk("rst_busy", 34'(bus.busy), 34'd0);
    chk("rst_done", 34'(bus.done), 34'd0);
    chk("rst_err", 34'(bus.err), 34'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rdy_after_rst", 34'(bus.rx_ready), 34'd1);

    // Basic single pixel.
    send(8'hA5, 0);
    send(8'h5A, 0);
    chk("t1_busy", 34'(bus.busy), 34'd1);
    send(8'h12, 0);
    chk("t1_no_early_we", 34'(bus.we), 34'd0);
    send(8'h34, 0);
    chk("t1_we", 34'(bus.we), 34'd1);
    chk("t1_waddr", 34'(bus.waddr), 34'd0);
    chk("t1_wdata", 34'(bus.wdata), 34'h1234);
    exp_q.push_back({18'd0, 16'h1234});
    close_abort("t1_close");
    chk("t1_hold_wdata", 34'(bus.wdata), 34'h1234);
    drain("t1");

    // Repeated SYNC0 before SYNC1.
    send(8'hA5, 0);
    send(8'hA5, 0);
    send(8'h5A, 0);
    send(8'h00, 0);
    send(8'hFF, 0);
    chk("t2_wdata", 34'(bus.wdata), 34'h00FF);
    exp_q.push_back({18'd0, 16'h00FF});
    close_abort("t2_close");
    drain("t2");

    // Rejected header leaves the loader hunting.
    send(8'hA5, 0);
    send(8'h77, 0);
    send(8'h5A, 0);
    send(8'h12, 0);
    chk("t3_busy", 34'(bus.busy), 34'd0);
    drain("t3");

    // Random full frames against a pixel-list model.
    for (int f = 0; f < 3; f++) begin
      nd0 = n_done;
      nr0 = n_nrdy;
      ne0 = n_err;
      for (int g = 0; g < 3; g++) begin
        b = 8'($urandom_range(0, 255));
        if (b == 8'hA5) b = 8'h00;
        send(b, $urandom_range(0, 3));
      end
      send(8'hA5, $urandom_range(0, 3));
      send(8'h5A, $urandom_range(0, 3));
      for (int i = 0; i < 8; i++) begin
        hi = 8'($urandom);
        lo = 8'($urandom);
        exp_q.push_back({18'(i), hi, lo});
        send(hi, $urandom_range(0, 6));
        send(lo, $urandom_range(0, 6));
      end
      chk("fr_last_we", 34'(bus.we), 34'd1);
      chk("fr_last_waddr", 34'(bus.waddr), 34'd7);
      chk("fr_fin_busy", 34'(bus.busy), 34'd0);
      chk("fr_fin_rdy", 34'(bus.rx_ready), 34'd0);
      chk("fr_fin_done", 34'(bus.done), 34'd0);
      if (f == 2) bus.abort = 1'b1;
      @(negedge clk);
      bus.abort = 1'b0;
      chk("fr_done", 34'(bus.done), 34'd1);
      chk("fr_done_err", 34'(bus.err), 34'd0);
      chk("fr_done_rdy", 34'(bus.rx_ready), 34'd1);
      @(negedge clk);
      chk("fr_done_pulse", 34'(bus.done), 34'd0);
      drain("fr");
      chk("fr_nrdy_cycles", 34'(n_nrdy - nr0), 34'd1);
      chk("fr_ndone", 34'(n_done - nd0), 34'd1);
      chk("fr_nerr", 34'(n_err - ne0), 34'd0);
    end

    // Inter-byte timeout drops the partial pixel.
    send(8'hA5, 0);
    send(8'h5A, 0);
    send(8'hAB, 0);
    repeat (15) @(negedge clk);
    chk("to_early_err", 34'(bus.err), 34'd0);
    chk("to_early_busy", 34'(bus.busy), 34'd1);
    @(negedge clk);
    chk("to_err", 34'(bus.err), 34'd1);
    chk("to_busy", 34'(bus.busy), 34'd0);
    drain("to_nowrite");
    send(8'hA5, 0);
    send(8'h5A, 0);
    send(8'h01, 0);
    send(8'h02, 0);
    chk("to_next_waddr", 34'(bus.waddr), 34'd0);
    chk("to_next_wdata", 34'(bus.wdata), 34'h0102);
    exp_q.push_back({18'd0, 16'h0102});
    close_abort("to_close");
    drain("to_next");

    // Abort coinciding with timeout gives a single err pulse.
    ne0 = n_err;
    send(8'hA5, 0);
    send(8'h5A, 0);
    send(8'hCD, 0);
    repeat (15) @(negedge clk);
    bus.abort = 1'b1;
    @(negedge clk);
    bus.abort = 1'b0;
    chk("to_ab_err", 34'(bus.err), 34'd1);
    repeat (2) @(negedge clk);
    chk("to_ab_nerr", 34'(n_err - ne0), 34'd1);
    drain("to_ab");

    // Abort after three pixels, with a byte offered in the same cycle.
    send(8'hA5, 0);
    send(8'h5A, 0);
    for (int i = 0; i < 3; i++) begin
      hi = 8'($urandom);
      lo = 8'($urandom);
      exp_q.push_back({18'(i), hi, lo});
      send(hi, 0);
      send(lo, 0);
    end
    bus.rx_data  = 8'h99;
    bus.rx_valid = 1'b1;
    bus.abort    = 1'b1;
    @(negedge clk);
    bus.rx_valid = 1'b0;
    bus.abort    = 1'b0;
    chk("ab_err", 34'(bus.err), 34'd1);
    chk("ab_busy", 34'(bus.busy), 34'd0);
    chk("ab_we", 34'(bus.we), 34'd0);
    drain("ab");
    ne0 = n_err;
    bus.abort = 1'b1;
    @(negedge clk);
    bus.abort = 1'b0;
    @(negedge clk);
    chk("ab_idle_noerr", 34'(n_err - ne0), 34'd0);

    // Asynchronous reset in the middle of a frame.
    nd0 = n_done;
    ne0 = n_err;
    send(8'hA5, 0);
    send(8'h5A, 0);
    send(8'h11, 0);
    send(8'h22, 0);
    send(8'h33, 0);
    send(8'h44, 0);
    send(8'h55, 0);
    exp_q.push_back({18'd0, 16'h1122});
    exp_q.push_back({18'd1, 16'h3344});
    chk("mr_pre_waddr", 34'(bus.waddr), 34'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("mr_we", 34'(bus.we), 34'd0);
    chk("mr_waddr", 34'(bus.waddr), 34'd0);
    chk("mr_wdata", 34'(bus.wdata), 34'd0);
    chk("mr_busy", 34'(bus.busy), 34'd0);
    chk("mr_rdy", 34'(bus.rx_ready), 34'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("mr_ndone", 34'(n_done - nd0), 34'd0);
    chk("mr_nerr", 34'(n_err - ne0), 34'd0);
    chk("mr_rdy_after", 34'(bus.rx_ready), 34'd1);
    drain("mr");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
